// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/writeback
// and decoding every datapath enable, mux select and the ALU function code.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP
  } state_t;

  state_t     state_q, state_d, out_state;
  logic       illegal_q, illegal_d;
  logic [2:0] funct_alu;
  logic       funct_ok;
  logic       pcwrite, branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = S_RTYPEEX;
          OP_BEQ:           state_d = S_BRANCH;
          OP_ADDI, OP_ORI:  state_d = S_IMMEX;
          OP_J:             state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: begin
        state_d = S_ALUWB;
        if (!funct_ok) illegal_d = 1'b1;
      end
      S_IMMEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Reset presents FETCH selects immediately, with every write enable suppressed.
  always_comb begin
    out_state  = reset ? S_FETCH : state_q;
    alucontrol = ALU_AND;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (out_state)
      S_FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = (op == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IMMWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
    end
    pcen = pcwrite | (branch & zero);
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by cycle and
// compares the full output vector against hand-written per-state expectations.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       iord, memtoreg, regdst, irwrite, memwrite, regwrite, pcen, illegal;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .irwrite(irwrite),
    .memwrite(memwrite), .regwrite(regwrite), .pcen(pcen), .illegal(illegal)
  );

  // {alucontrol, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst, irwrite, memwrite, regwrite, pcen}
  localparam logic [14:0] V_RST    = {3'b010, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] V_FETCH  = {3'b010, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [14:0] V_DECODE = {3'b010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] V_MEMADR = {3'b010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] V_MEMRD  = {3'b000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] V_MEMWB  = {3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [14:0] V_MEMWR  = {3'b000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] V_ALUWB  = {3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [14:0] V_IMMWB  = {3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [14:0] V_JUMP   = {3'b000, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  function automatic logic [14:0] v_rtype(input logic [2:0] alu);
    return {alu, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic logic [14:0] v_immex(input logic [2:0] alu);
    return {alu, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic logic [14:0] v_branch(input logic taken);
    return {3'b110, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, taken};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
  endtask

  // Check the current state's outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [14:0] exp_v);
    #1;
    chk(tag, {17'd0, alucontrol, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
              irwrite, memwrite, regwrite, pcen}, {17'd0, exp_v});
    $display("cycle %-16s outs=%h exp=%h illegal=%0b", tag, {alucontrol, alusrca, alusrcb,
             pcsrc, iord, memtoreg, regdst, irwrite, memwrite, regwrite, pcen}, exp_v, illegal);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset_held", V_RST);
    reset = 1'b0;
  endtask

  logic [5:0] r_funct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] r_alu   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    reset = 1'b1; op = 6'b0; funct = 6'b100000; zero = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset_state", V_RST);
    #1 chk("reset_illegal", {31'd0, illegal}, 32'd0);
    reset = 1'b0;

    op = 6'b100011;
    cyc("lw_fetch", V_FETCH);
    cyc("lw_decode", V_DECODE);
    cyc("lw_memadr", V_MEMADR);
    cyc("lw_memrd", V_MEMRD);
    cyc("lw_memwb", V_MEMWB);

    op = 6'b101011;
    cyc("sw_fetch", V_FETCH);
    cyc("sw_decode", V_DECODE);
    cyc("sw_memadr", V_MEMADR);
    cyc("sw_memwr", V_MEMWR);

    op = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      funct = r_funct[i];
      cyc("r_fetch", V_FETCH);
      cyc("r_decode", V_DECODE);
      cyc($sformatf("r_ex_%b", r_funct[i]), v_rtype(r_alu[i]));
      cyc("r_aluwb", V_ALUWB);
    end

    op = 6'b000100; zero = 1'b1;
    cyc("beq_t_fetch", V_FETCH);
    cyc("beq_t_decode", V_DECODE);
    cyc("beq_taken", v_branch(1'b1));
    zero = 1'b0;
    cyc("beq_nt_fetch", V_FETCH);
    cyc("beq_nt_decode", V_DECODE);
    cyc("beq_not_taken", v_branch(1'b0));

    op = 6'b001101;
    cyc("ori_fetch", V_FETCH);
    cyc("ori_decode", V_DECODE);
    cyc("ori_immex", v_immex(3'b001));
    cyc("ori_immwb", V_IMMWB);
    op = 6'b001000;
    cyc("addi_fetch", V_FETCH);
    cyc("addi_decode", V_DECODE);
    cyc("addi_immex", v_immex(3'b010));
    cyc("addi_immwb", V_IMMWB);

    op = 6'b000010;
    cyc("j_fetch", V_FETCH);
    cyc("j_decode", V_DECODE);
    cyc("j_jump", V_JUMP);

    chk("illegal_before", {31'd0, illegal}, 32'd0);
    op = 6'b111111;
    cyc("bad_fetch", V_FETCH);
    cyc("bad_decode", V_DECODE);
    chk("illegal_set", {31'd0, illegal}, 32'd1);
    op = 6'b000000; funct = 6'b100000;
    cyc("add_after_bad", V_FETCH);
    cyc("add_decode", V_DECODE);
    cyc("add_ex", v_rtype(3'b010));
    cyc("add_aluwb", V_ALUWB);
    chk("illegal_sticky", {31'd0, illegal}, 32'd1);
    do_reset();
    chk("illegal_cleared", {31'd0, illegal}, 32'd0);

    funct = 6'b111111;
    cyc("badf_fetch", V_FETCH);
    cyc("badf_decode", V_DECODE);
    cyc("badf_ex", v_rtype(3'b010));
    cyc("badf_aluwb", V_ALUWB);
    chk("illegal_funct", {31'd0, illegal}, 32'd1);
    do_reset();

    op = 6'b100011;
    cyc("lwa_fetch", V_FETCH);
    cyc("lwa_decode", V_DECODE);
    cyc("lwa_memadr", V_MEMADR);
    reset = 1'b1;
    cyc("lwa_memrd_rst", V_RST);
    reset = 1'b0;
    cyc("lwa_refetch", V_FETCH);
    cyc("lwa_redecode", V_DECODE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
